// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared types and constants for the sequential binary-to-BCD converter.
//   - BCD_DIGIT_W : width of one packed BCD digit
//   - bcd_digit_t : one BCD digit
//   - b2b_state_t : converter FSM states
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble digit correction: a digit of 5 or more gets +3
//   so that the following left shift carries correctly into the next decade.
//   Ports:
//     din  in   bcd_digit_t   digit before correction
//     dout out  bcd_digit_t   corrected digit (4-bit add, no carry out)
// -----------------------------------------------------------------------------
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    // Add-3 correction; inputs are at most 9, so the 4-bit sum cannot wrap.
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3). One WIDTH-bit
//   unsigned value is converted per request in WIDTH SHIFT cycles; the result
//   feeds 7-segment decoders directly, one digit per decoder.
//   Ports:
//     clk    in   1          clock, all state updates on posedge
//     rst    in   1          synchronous active-high reset
//     start  in   1          conversion request (accepted in IDLE or DONE)
//     bin    in   WIDTH      value to convert, sampled on the accepting edge
//     busy   out  1          high while converting (SHIFT state)
//     done   out  1          one-cycle pulse, bcd/ovf hold a new result
//     bcd    out  4*DIGITS   packed BCD result, digit0 in bits [3:0]
//     ovf    out  1          result exceeded DIGITS digits (bcd is wrapped)
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SH_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    b2b_state_t        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [SH_W-1:0]   shreg_q,   shreg_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]  bcd_q,     bcd_d;
    logic              ovf_q,     ovf_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    logic [BCD_W-1:0]  adj_digits_s;
    logic [SH_W-1:0]   adj_s;
    logic [SH_W-1:0]   shifted_s;
    logic              out_bit_s;

    // Per-digit add-3 correction on the BCD half of the shift register.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (shreg_q[WIDTH + BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
            .dout (adj_digits_s[BCD_DIGIT_W*gi +: BCD_DIGIT_W])
        );
    end

    // Corrected register, its left shift, and the bit pushed out of the top digit.
    always_comb begin
        adj_s     = {adj_digits_s, shreg_q[WIDTH-1:0]};
        shifted_s = {adj_s[SH_W-2:0], 1'b0};
        out_bit_s = adj_s[SH_W-1];
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SHIFT;
                    cnt_d     = {CNT_W{1'b0}};
                    shreg_d   = {{BCD_W{1'b0}}, bin};
                    ovf_acc_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                shreg_d   = shifted_s;
                ovf_acc_d = ovf_acc_q | out_bit_s;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last shift: publish the result including this edge's carry-out.
                    state_d = DONE;
                    bcd_d   = shifted_s[SH_W-1 -: BCD_W];
                    ovf_d   = ovf_acc_q | out_bit_s;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the next state so they register with it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            SHIFT:   busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            shreg_q   <= {SH_W{1'b0}};
            ovf_acc_q <= 1'b0;
            bcd_q     <= {BCD_W{1'b0}};
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq. Two instances share clk/rst: a
//   16-bit/5-digit one and a 16-bit/4-digit one for the overflow cases.
//   Expected results come from plain decimal arithmetic on the input value.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start5 = 1'b0;
    logic [15:0] bin5 = 16'd0;
    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic        start4 = 1'b0;
    logic [15:0] bin4 = 16'd0;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] prev_bcd [2];
    logic        prev_ovf [2];
    logic [15:0] bin_hist [35];

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .bin(bin5),
        .busy(busy5), .done(done5), .bcd(bcd5), .ovf(ovf5)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v modulo 10^digits, packed one per nibble.
    function automatic logic [19:0] ref_bcd(input int unsigned v, input int digits);
        logic [19:0]  r;
        int unsigned  x;
        r = 20'd0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int digits);
        int unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return (v >= p);
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done4 : done5;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy4 : busy5;
    endfunction

    function automatic logic [19:0] get_bcd(input bit sel);
        return sel ? {4'h0, bcd4} : bcd5;
    endfunction

    function automatic logic get_ovf(input bit sel);
        return sel ? ovf4 : ovf5;
    endfunction

    task automatic drive(input bit sel, input logic s, input logic [15:0] v);
        if (sel) begin
            start4 = s;
            bin4   = v;
        end else begin
            start5 = s;
            bin5   = v;
        end
    endtask

    // One conversion from idle; optionally pokes start/bin while busy.
    task automatic convert(input bit sel, input int unsigned v, input bit hammer);
        int  k;
        int  busy_cnt;
        bit  got_done;
        int  digits;
        digits   = sel ? 4 : 5;
        busy_cnt = 0;
        got_done = 1'b0;
        k        = 0;
        @(negedge clk);
        drive(sel, 1'b1, 16'(v));
        @(negedge clk);
        drive(sel, 1'b0, 16'($urandom_range(0, 65535)));
        while (!got_done && k < 40) begin
            if (get_done(sel)) begin
                got_done = 1'b1;
            end else begin
                if (get_busy(sel)) busy_cnt++;
                if (k == 8) begin
                    check_val("bcd_hold", 32'(get_bcd(sel)), 32'(prev_bcd[sel]));
                    check_val("ovf_hold", 32'(get_ovf(sel)), 32'(prev_ovf[sel]));
                end
                if (hammer && k < 15) drive(sel, 1'b1, 16'($urandom_range(0, 65535)));
                else drive(sel, 1'b0, 16'($urandom_range(0, 65535)));
                @(negedge clk);
                k++;
            end
        end
        drive(sel, 1'b0, 16'd0);
        if (!got_done) begin
            check_val("done_timeout", 32'd0, 32'd1);
        end else begin
            check_val("latency", 32'(k), 32'd16);
            check_val("busy_cycles", 32'(busy_cnt), 32'd16);
            check_val("bcd", 32'(get_bcd(sel)), 32'(ref_bcd(v, digits)));
            check_val("ovf", 32'(get_ovf(sel)), 32'(ref_ovf(v, digits)));
            check_val("busy_in_done", 32'(get_busy(sel)), 32'd0);
            prev_bcd[sel] = ref_bcd(v, digits);
            prev_ovf[sel] = ref_ovf(v, digits);
            @(negedge clk);
            check_val("done_pulse", 32'(get_done(sel)), 32'd0);
            check_val("idle_busy", 32'(get_busy(sel)), 32'd0);
        end
    endtask

    initial begin
        int unsigned v;
        bit          saw_done;
        prev_bcd[0] = 20'd0;
        prev_bcd[1] = 20'd0;
        prev_ovf[0] = 1'b0;
        prev_ovf[1] = 1'b0;

        // 1. reset, then idle without start
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_busy", 32'(busy5), 32'd0);
        check_val("rst_done", 32'(done5), 32'd0);
        check_val("rst_bcd", 32'(bcd5), 32'd0);
        check_val("rst_ovf", 32'(ovf5), 32'd0);
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done5 || done4) saw_done = 1'b1;
        end
        check_val("idle_no_done", 32'(saw_done), 32'd0);

        // 2-3. directed values
        convert(1'b0, 0, 1'b0);
        convert(1'b0, 1234, 1'b0);
        convert(1'b0, 65535, 1'b1);
        convert(1'b0, 9, 1'b0);
        check_val("bcd_9", 32'(bcd5), 32'h00009);

        // 4. start held high, bin changing every cycle
        @(negedge clk);
        start5 = 1'b1;
        for (int e = 0; e <= 33; e++) begin
            bin5 = (e == 0) ? 16'd42 : 16'($urandom_range(0, 65535));
            bin_hist[e] = bin5;
            @(negedge clk);
            if (e == 16) begin
                check_val("b2b_done1", 32'(done5), 32'd1);
                check_val("b2b_bcd1", 32'(bcd5), 32'h00042);
            end else if (e == 33) begin
                check_val("b2b_done2", 32'(done5), 32'd1);
                check_val("b2b_bcd2", 32'(bcd5), 32'(ref_bcd(32'(bin_hist[17]), 5)));
            end else if (e == 17) begin
                check_val("b2b_busy", 32'(busy5), 32'd1);
                check_val("b2b_nodone", 32'(done5), 32'd0);
            end else if (e == 5 || e == 25) begin
                check_val("b2b_nodone", 32'(done5), 32'd0);
            end
        end
        start5 = 1'b0;
        prev_bcd[0] = ref_bcd(32'(bin_hist[17]), 5);
        @(negedge clk);
        check_val("b2b_idle", 32'(busy5), 32'd0);

        // 5. reset in the middle of a conversion
        @(negedge clk);
        start5 = 1'b1;
        bin5   = 16'd999;
        @(negedge clk);
        start5 = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_busy", 32'(busy5), 32'd0);
        check_val("mid_rst_done", 32'(done5), 32'd0);
        check_val("mid_rst_bcd", 32'(bcd5), 32'd0);
        prev_bcd[0] = 20'd0;
        prev_bcd[1] = 20'd0;
        prev_ovf[0] = 1'b0;
        prev_ovf[1] = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done5) saw_done = 1'b1;
        end
        check_val("mid_rst_no_done", 32'(saw_done), 32'd0);
        convert(1'b0, 999, 1'b0);

        // 6. four-digit instance: overflow boundary
        convert(1'b1, 10000, 1'b0);
        convert(1'b1, 9999, 1'b0);

        // randomized conversions on both instances
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(0, 65535);
            convert(1'b0, v, 1'($urandom_range(0, 1)));
            v = $urandom_range(0, 65535);
            convert(1'b1, v, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bin2bcd_seq
